// File: rtl/ads5296_deser_align.sv
// ADS5296 DDR lane deserializer with automatic frame-based word alignment.
// All lanes share one bit offset, found by scanning until the frame lane matches FRAME_PATTERN.

module ads5296_lane_shift #(
    parameter int WORD_BITS = 10,
    parameter int OFF_W     = 4
) (
    input  logic                 lclk,
    input  logic                 rst_n,
    input  logic                 rise,
    input  logic                 fall,
    input  logic [OFF_W-1:0]     off,
    output logic [WORD_BITS-1:0] word
);
    logic                   rise_r;
    logic                   fall_r;
    logic [2*WORD_BITS-1:0] sr;

    // Two bits enter per cycle at the top; sr[0] is the oldest serial bit.
    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            sr     <= '0;
        end else begin
            rise_r <= rise;
            fall_r <= fall;
            sr     <= {fall_r, rise_r, sr[2*WORD_BITS-1:2]};
        end
    end

    assign word = WORD_BITS'(sr >> off);
endmodule

module ads5296_deser_align #(
    parameter int                   NLANES        = 2,
    parameter int                   WORD_BITS     = 10,
    parameter logic [WORD_BITS-1:0] FRAME_PATTERN = 10'b1111100000,
    parameter int                   LOCK_COUNT    = 16,
    parameter int                   UNLOCK_COUNT  = 4
) (
    input  logic                           lclk,
    input  logic                           rst_n,
    input  logic [NLANES-1:0]              din_rise,
    input  logic [NLANES-1:0]              din_fall,
    input  logic                           frame_rise,
    input  logic                           frame_fall,
    input  logic                           auto_en,
    input  logic [$clog2(WORD_BITS)-1:0]   man_offset,
    input  logic                           realign,
    output logic [NLANES*WORD_BITS-1:0]    dout,
    output logic                           dout_valid,
    output logic                           frame_ok,
    output logic                           locked,
    output logic                           align_fail,
    output logic [$clog2(WORD_BITS)-1:0]   offset_out,
    output logic [7:0]                     lock_loss_cnt
);
    localparam int HALF  = WORD_BITS / 2;
    localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int OFF_W = $clog2(WORD_BITS);
    localparam int MW    = $clog2(LOCK_COUNT + 1);
    localparam int EW    = $clog2(UNLOCK_COUNT + 1);
    localparam int TW    = $clog2(WORD_BITS + 1);

    typedef enum logic [2:0] {
        S_HUNT, S_VERIFY, S_LOCKED, S_FAIL, S_MANUAL
    } state_t;

    state_t                              state, state_n;
    logic [OFF_W-1:0]                    off, off_n, off_inc, man_cl, eff_off;
    logic [MW-1:0]                       match_cnt, match_n;
    logic [EW-1:0]                       err_cnt, err_n;
    logic [TW-1:0]                       tried_cnt, tried_n;
    logic [7:0]                          loss_n;
    logic                                pend, pend_n;
    logic [PH_W-1:0]                     ph;
    logic                                cap;
    logic [NLANES-1:0][WORD_BITS-1:0]    lane_word;
    logic [WORD_BITS-1:0]                frame_now;
    logic                                match;

    assign cap     = (ph == PH_W'(HALF - 1));
    assign man_cl  = (man_offset > OFF_W'(WORD_BITS - 1)) ? OFF_W'(WORD_BITS - 1) : man_offset;
    // The offset register only matters at capture, so offset changes land on word boundaries.
    assign eff_off = auto_en ? off : man_cl;
    assign off_inc = (off == OFF_W'(WORD_BITS - 1)) ? '0 : off + OFF_W'(1);
    assign match   = (frame_now == FRAME_PATTERN);

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        ads5296_lane_shift #(.WORD_BITS(WORD_BITS), .OFF_W(OFF_W)) u_lane (
            .lclk  (lclk),
            .rst_n (rst_n),
            .rise  (din_rise[k]),
            .fall  (din_fall[k]),
            .off   (eff_off),
            .word  (lane_word[k])
        );
    end

    ads5296_lane_shift #(.WORD_BITS(WORD_BITS), .OFF_W(OFF_W)) u_frame (
        .lclk  (lclk),
        .rst_n (rst_n),
        .rise  (frame_rise),
        .fall  (frame_fall),
        .off   (eff_off),
        .word  (frame_now)
    );

    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            ph         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_ok   <= 1'b0;
            offset_out <= '0;
        end else begin
            ph         <= cap ? '0 : ph + PH_W'(1);
            dout_valid <= cap;
            if (cap) begin
                dout       <= lane_word;
                frame_ok   <= match;
                offset_out <= eff_off;
            end
        end
    end

    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_HUNT;
            off           <= '0;
            match_cnt     <= '0;
            err_cnt       <= '0;
            tried_cnt     <= '0;
            lock_loss_cnt <= '0;
            pend          <= 1'b0;
        end else begin
            state         <= state_n;
            off           <= off_n;
            match_cnt     <= match_n;
            err_cnt       <= err_n;
            tried_cnt     <= tried_n;
            lock_loss_cnt <= loss_n;
            pend          <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        off_n   = off;
        match_n = match_cnt;
        err_n   = err_cnt;
        tried_n = tried_cnt;
        loss_n  = lock_loss_cnt;
        pend_n  = pend;
        if (!auto_en) begin
            state_n = S_MANUAL;
            match_n = '0;
            err_n   = '0;
            tried_n = '0;
            pend_n  = 1'b0;
            if (cap) off_n = man_cl;
        end else if (state == S_MANUAL) begin
            state_n = S_HUNT;
            tried_n = '0;
            if (realign) pend_n = 1'b1;
        end else if (cap) begin
            pend_n = 1'b0;
            // A realign held since mid-word overrides whatever this frame word says.
            if (pend || realign) begin
                state_n = S_HUNT;
                off_n   = '0;
                match_n = '0;
                err_n   = '0;
                tried_n = '0;
            end else begin
                case (state)
                    S_HUNT: begin
                        if (match) begin
                            match_n = MW'(1);
                            state_n = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;
                        end else begin
                            off_n   = off_inc;
                            tried_n = tried_cnt + TW'(1);
                            if (tried_cnt + TW'(1) == TW'(WORD_BITS)) state_n = S_FAIL;
                        end
                    end
                    S_VERIFY: begin
                        if (match) begin
                            match_n = match_cnt + MW'(1);
                            if (match_cnt + MW'(1) == MW'(LOCK_COUNT)) state_n = S_LOCKED;
                        end else begin
                            state_n = S_HUNT;
                            off_n   = off_inc;
                            match_n = '0;
                        end
                    end
                    S_LOCKED: begin
                        if (match) begin
                            err_n = '0;
                        end else begin
                            err_n = err_cnt + EW'(1);
                            if (err_cnt + EW'(1) == EW'(UNLOCK_COUNT)) begin
                                state_n = S_HUNT;
                                err_n   = '0;
                                match_n = '0;
                                tried_n = '0;
                                loss_n  = (lock_loss_cnt == 8'hFF) ? 8'hFF : lock_loss_cnt + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end else if (realign) begin
            pend_n = 1'b1;
        end
    end

    assign locked     = (state == S_LOCKED);
    assign align_fail = (state == S_FAIL);
endmodule

// File: tb/tb_ads5296_deser_align.sv
// Randomized bench for ads5296_deser_align: serial streams are recorded bit by bit and a
// per-capture alignment model predicts each output word; a monitor checks every dout_valid.

module tb_ads5296_deser_align;
    localparam int NL = 2, W = 10, HALF = 5, LOCKN = 16, UNLOCKN = 4, OW = 4;
    localparam int MAXB = 8000, MAXJ = 1000;
    localparam logic [W-1:0] PAT = 10'b1111100000;
    localparam int MH = 0, MV = 1, ML = 2, MF = 3, MM = 4;

    logic            lclk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NL-1:0]   din_rise = '0, din_fall = '0;
    logic            frame_rise = 1'b0, frame_fall = 1'b0;
    logic            auto_en = 1'b1, realign = 1'b0;
    logic [OW-1:0]   man_offset = '0;
    logic [NL*W-1:0] dout;
    logic            dout_valid, frame_ok, locked, align_fail;
    logic [OW-1:0]   offset_out;
    logic [7:0]      lock_loss_cnt;

    always #5 lclk = ~lclk;

    ads5296_deser_align dut (
        .lclk(lclk), .rst_n(rst_n), .din_rise(din_rise), .din_fall(din_fall),
        .frame_rise(frame_rise), .frame_fall(frame_fall), .auto_en(auto_en),
        .man_offset(man_offset), .realign(realign), .dout(dout), .dout_valid(dout_valid),
        .frame_ok(frame_ok), .locked(locked), .align_fail(align_fail),
        .offset_out(offset_out), .lock_loss_cnt(lock_loss_cnt)
    );

    typedef struct {
        logic [NL*W-1:0] d;
        logic            fok, lk, fl;
        logic [OW-1:0]   off;
        logic [7:0]      loss;
    } exp_t;

    int   checks = 0, failures = 0;
    int   cyc = 0;
    int   shift;
    bit   fzero = 0;
    bit   fb [MAXB];
    bit   db [NL][MAXB];
    bit   fbad [MAXJ];
    logic [W-1:0] rnd [MAXJ];
    exp_t q[$];

    int m_st, m_off, m_match, m_err, m_tried, m_loss;
    bit m_pend;

    // Word j of the stream starts at serial bit shift + W*j; lane 0 carries a ramp.
    function automatic logic [W-1:0] src_word(int lane, int j);
        if (j >= MAXJ) return '0;
        if (lane < 0) return fzero ? '0 : (fbad[j] ? ~PAT : PAT);
        if (lane == 0) return W'(j + 1);
        return rnd[j] ^ W'(lane - 1);
    endfunction

    function automatic bit gen_bit(int lane, int b);
        int rel;
        logic [W-1:0] w;
        rel = b - shift;
        if (rel < 0) return 1'b0;
        w = src_word(lane, rel / W);
        return w[rel % W];
    endfunction

    function automatic logic [W-1:0] sample(int lane, int start);
        logic [W-1:0] w;
        int b;
        w = '0;
        for (int i = 0; i < W; i++) begin
            b = start + i;
            if (b >= 0) w[i] = (lane < 0) ? fb[b] : db[lane][b];
        end
        return w;
    endfunction

    task automatic drive_pair();
        int b;
        b = 2 * cyc;
        if (b + 1 >= MAXB) begin
            $display("FAIL stream_overflow actual=%0d limit=%0d", b, MAXB);
            failures++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1);
        end
        for (int k = -1; k < NL; k++) begin
            for (int h = 0; h < 2; h++) begin
                if (k < 0) fb[b + h] = gen_bit(k, b + h);
                else       db[k][b + h] = gen_bit(k, b + h);
            end
        end
        frame_rise = fb[b];
        frame_fall = fb[b + 1];
        for (int k = 0; k < NL; k++) begin
            din_rise[k] = db[k][b];
            din_fall[k] = db[k][b + 1];
        end
    endtask

    task automatic model_reset();
        m_st = MH; m_off = 0; m_match = 0; m_err = 0; m_tried = 0; m_loss = 0; m_pend = 0;
    endtask

    // One call per lclk edge; cyc is the edge count since reset release.
    task automatic model_edge();
        bit cap, fm;
        int eff, mcl, start;
        exp_t e;
        cap = (cyc >= HALF) && (cyc % HALF == 0);
        mcl = (int'(man_offset) > W - 1) ? W - 1 : int'(man_offset);
        fm  = 1'b0;
        if (cap) begin
            eff   = auto_en ? m_off : mcl;
            start = 2 * cyc - 2 * W - 4 + eff;
            for (int k = 0; k < NL; k++) e.d[k*W +: W] = sample(k, start);
            fm    = (sample(-1, start) == PAT);
            e.fok = fm;
            e.off = OW'(eff);
        end
        if (!auto_en) begin
            m_st = MM; m_match = 0; m_err = 0; m_tried = 0; m_pend = 0;
            if (cap) m_off = mcl;
        end else if (m_st == MM) begin
            m_st = MH; m_tried = 0;
            if (realign) m_pend = 1;
        end else if (cap) begin
            if (m_pend || realign) begin
                m_st = MH; m_off = 0; m_match = 0; m_err = 0; m_tried = 0;
            end else if (m_st == MH) begin
                if (fm) begin
                    m_match = 1; m_st = MV;
                end else begin
                    m_off = (m_off + 1) % W; m_tried++;
                    if (m_tried >= W) m_st = MF;
                end
            end else if (m_st == MV) begin
                if (fm) begin
                    m_match++;
                    if (m_match >= LOCKN) m_st = ML;
                end else begin
                    m_st = MH; m_off = (m_off + 1) % W; m_match = 0;
                end
            end else if (m_st == ML) begin
                if (fm) m_err = 0;
                else begin
                    m_err++;
                    if (m_err >= UNLOCKN) begin
                        m_st = MH; m_err = 0; m_match = 0; m_tried = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
            end
            m_pend = 0;
        end else if (realign) begin
            m_pend = 1;
        end
        if (cap) begin
            e.lk   = (m_st == ML);
            e.fl   = (m_st == MF);
            e.loss = 8'(m_loss);
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge lclk);
        cyc++;
        model_edge();
        #1;
        realign = 1'b0;
        drive_pair();
    endtask

    task automatic step_to(int ph);
        for (int i = 0; i < HALF && (cyc % HALF) != ph; i++) step();
    endtask

    task automatic pulse_realign();
        realign = 1'b1;
        step();
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic release_reset();
        @(negedge lclk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        model_reset();
        for (int j = 0; j < MAXJ; j++) fbad[j] = 1'b0;
        q.delete();
        drive_pair();
    endtask

    always @(negedge lclk) begin
        exp_t e;
        logic exp_v;
        exp_v = rst_n && (cyc >= HALF) && (cyc % HALF == 0);
        checks++;
        if (dout_valid !== exp_v) begin
            failures++;
            $display("FAIL valid_cadence cyc=%0d actual=%b expected=%b", cyc, dout_valid, exp_v);
        end
        if (rst_n && dout_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL word_unexpected cyc=%0d actual=valid expected=no_word", cyc);
            end else begin
                e = q.pop_front();
                if (dout !== e.d || frame_ok !== e.fok || locked !== e.lk ||
                    align_fail !== e.fl || offset_out !== e.off || lock_loss_cnt !== e.loss) begin
                    failures++;
                    $display("FAIL word cyc=%0d actual d=%h fok=%b lk=%b fl=%b off=%0d loss=%0d expected d=%h fok=%b lk=%b fl=%b off=%0d loss=%0d",
                             cyc, dout, frame_ok, locked, align_fail, offset_out, lock_loss_cnt,
                             e.d, e.fok, e.lk, e.fl, e.off, e.loss);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int order [W];
        int cur_j, tmp, r;
        for (int j = 0; j < MAXJ; j++) rnd[j] = W'($urandom);
        shift = 3 + 6;
        #12;
        chk("reset_state", {dout, dout_valid, frame_ok, locked, align_fail, offset_out, lock_loss_cnt}, 0);
        release_reset();

        // Natural search from reset with true alignment 3.
        repeat (180) step();
        chk("lockA_locked", locked, 1);
        chk("lockA_offset", offset_out, 3);

        // 3 bad, 1 good, 4 bad frame words.
        cur_j = (2 * cyc - shift) / W;
        for (int j = 0; j < 3; j++) fbad[cur_j + 3 + j] = 1'b1;
        for (int j = 0; j < 4; j++) fbad[cur_j + 7 + j] = 1'b1;
        repeat (200) step();
        chk("loss_relocked", locked, 1);
        chk("loss_offset", offset_out, 3);
        chk("loss_count", lock_loss_cnt, 1);

        // Dead frame lane exhausts all offsets.
        fzero = 1'b1;
        repeat (10) step();
        pulse_realign();
        repeat (90) step();
        chk("fail_flag", align_fail, 1);
        chk("fail_locked", locked, 0);
        chk("fail_offset", offset_out, 0);
        fzero = 1'b0;
        repeat (20) step();
        pulse_realign();
        repeat (180) step();
        chk("recover_locked", locked, 1);
        chk("recover_fail", align_fail, 0);

        // Every alignment in random order, each found from offset 0 after realign.
        for (int i = 0; i < W; i++) order[i] = i;
        for (int i = W - 1; i > 0; i--) begin
            r = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[r]; order[r] = tmp;
        end
        for (int i = 0; i < W; i++) begin
            shift = order[i] + 6;
            repeat (15) step();
            pulse_realign();
            repeat (180) step();
            chk($sformatf("sweep_lock_a%0d", order[i]), {locked, 4'(offset_out)}, {1'b1, 4'(order[i])});
        end

        // Manual offset 7, first against a misaligned stream, then an aligned one.
        step_to(2);
        auto_en    = 1'b0;
        man_offset = 4'd7;
        shift      = ((8 + $urandom_range(0, 8)) % W) + 6;
        repeat (40) step();
        shift = 7 + 6;
        repeat (40) step();
        chk("manual_offset", offset_out, 7);
        chk("manual_flags", {locked, align_fail, frame_ok}, 3'b001);
        step_to(2);
        auto_en = 1'b1;
        repeat (130) step();
        chk("auto_from_manual", {locked, 4'(offset_out)}, {1'b1, 4'd7});

        // Asynchronous reset in the middle of a word while locked.
        step_to(2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_zero", {dout, dout_valid, frame_ok, locked, align_fail, offset_out, lock_loss_cnt}, 0);
        q.delete();
        repeat (3) @(posedge lclk);
        release_reset();
        repeat (180) step();
        chk("postreset_lock", {locked, 4'(offset_out), lock_loss_cnt}, {1'b1, 4'd7, 8'd0});

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
